tia_hmove_ctrl: RTL and testbench
=================================

Name: tia_hmove_ctrl

Overview:
Horizontal-motion sequencer for the TIA object position counters (P0, P1, M0, M1, BL). On an HMOVE strobe it runs a 15-step motion sequence and emits extra clock pulses per object according to each object's 4-bit HMxx value. It also generates the 8-colour-clock "late HBLANK" extension that compensates for the nominal 8 extra pulses. It sits between the TIA write-register file (HMxx values, HMOVE strobe) and the object counters/blank logic, clocked by the TIA colour-clock enable.

Parameters:
STEP_TICKS, 4, ce ticks between motion steps
NUM_STEPS, 15, steps per HMOVE sequence (max pulses per object)
LATE_BLANK_LEN, 8, visible ce ticks masked after HBLANK falls

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ce  in  1  colour-clock enable; all state advances only when ce=1
hmove  in  1  HMOVE strobe; sampled only when ce=1
hblank  in  1  current horizontal blank from the video generator
hm  in  20  motion values {BL,M1,M0,P1,P0}, 4 bits each, two's complement as written to D7-4
mclk  out  5  extra-clock pulses {BL,M1,M0,P1,P0}; one clk wide, only on ce cycles
busy  out  1  sequence in progress
late_blank  out  1  extended-blank mask, to be ORed with hblank downstream

Behaviour:
- Reset: mclk=0, busy=0, late_blank=0; tick counter, step counter, lane flags cleared. Reset mid-sequence aborts without further pulses.
- Per-object target T = hm[obj] XOR 4'h8 (0..15): +7 -> 15 pulses (7 px left); 0 -> 8 (no net motion); -8 -> 0 (8 px right).
- Start: ce=1 and hmove=1 -> tick counter=0, step=0, busy=1, every lane with T!=0 marked active; T latched per lane.
- Steps: occur at ce ticks 4,8,...,60 after the strobe tick (strobe tick = tick 0). At step k (1..15), each active lane pulses mclk on that ce cycle; lane deactivates after the step where k==T. No pulse is emitted on the strobe tick.
- busy drops on the ce tick after step 15 (tick 61). Total pulses per lane = T exactly.
- Retrigger: hmove while busy restarts the sequence at tick 0; lane activity re-evaluated from current hm; pulses of the aborted sequence are not completed.
- late_blank: set on an hmove ce tick if hblank=1. While set, counts ce ticks with hblank=0; cleared on the LATE_BLANK_LEN-th such tick (high for exactly 8 visible ticks). hmove with hblank=0 does not set it. hmove while late_blank already set and hblank=1 keeps it set and restarts nothing else.
- hm changes mid-sequence have no effect (latched) unless the optional feature is enabled.
- ce=0 cycles: all outputs hold except mclk, which is 0.

Optional Feature:
TIA_HMOVE_LIVE_CMP_EN
- Defined: no target latching; at each step, a lane deactivates when k > hm[obj]^8 evaluated live at that step; once deactivated it stays off until the next hmove (reproduces mid-HMOVE write artefacts).
- Undefined: targets latched at the strobe tick, as above.

Decomposition:
- tia_pkg: object index constants OBJ_P0=0, OBJ_P1=1, OBJ_M0=2, OBJ_M1=3, OBJ_BL=4, NUM_OBJ=5; HM_BIAS=4'h8.
- Sub-module tia_motion_lane (one per object, 5 instances): active flag, target latch/compare, mclk pulse generation; inputs start, step, k, hm nibble.

Test Plan:
- hm all 0 (T=8), hmove on ce with hblank=1 -> each mclk bit pulses 8 times at ticks 4..32; busy high ticks 1..60, low at tick 61.
- hm P0=4'h7, P1=4'h8, BL=4'hF (T=15,0,7) -> mclk[0] 15 pulses (ticks 4..60), mclk[1] none, mclk[4] 7 pulses (ticks 4..28).
- hmove with hblank=1, hblank falls 20 ticks later -> late_blank high from strobe until 8th ce tick after the fall, then 0.
- hmove with hblank=0 -> late_blank stays 0; pulses still produced per T.
- Retrigger at tick 18 (after 4 pulses, T=8) -> new 8 pulses starting 4 ticks after retrigger; total 12 pulses; busy continuous.
- Change P0 hm 0->4'h7 at tick 10: undefined macro -> 8 pulses; TIA_HMOVE_LIVE_CMP_EN -> 15 pulses. Reset asserted at tick 30 -> mclk, busy, late_blank 0 next clk.

Source files
------------

// File: rtl/tia_pkg.sv
// Shared constants, state types and helpers for the TIA horizontal-motion sequencer.
package tia_pkg;

  localparam int OBJ_P0  = 0;
  localparam int OBJ_P1  = 1;
  localparam int OBJ_M0  = 2;
  localparam int OBJ_M1  = 3;
  localparam int OBJ_BL  = 4;
  localparam int NUM_OBJ = 5;

  localparam logic [3:0] HM_BIAS = 4'h8;

  localparam int STEP_TICKS_DEF     = 4;
  localparam int NUM_STEPS_DEF      = 15;
  localparam int LATE_BLANK_LEN_DEF = 8;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_RUN  = 1'b1
  } seq_state_t;

  typedef enum logic {
    LB_OFF = 1'b0,
    LB_ON  = 1'b1
  } lb_state_t;

  // HMxx is two's complement in D7-4; biasing by 8 turns it into a 0..15 pulse count.
  function automatic logic [3:0] hmTarget(input logic [3:0] hmNib);
    return hmNib ^ HM_BIAS;
  endfunction

endpackage

// File: rtl/tia_motion_lane.sv
// One object's motion lane: active flag, target compare and extra-clock pulse.
// TIA_HMOVE_LIVE_CMP_EN compares against the live HMxx value instead of a latched target.
module tia_motion_lane
  import tia_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic       i_step,
  input  logic [3:0] i_k,
  input  logic [3:0] i_hm,
  output logic       o_pulse
);

  logic       r_active;
  logic [3:0] w_liveTarget;

  assign w_liveTarget = hmTarget(i_hm);

`ifdef TIA_HMOVE_LIVE_CMP_EN
  logic w_inRange;

  // Once the step index passes the live target the lane is done until the next strobe.
  assign w_inRange = (i_k <= w_liveTarget);
  assign o_pulse   = i_step & r_active & w_inRange;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_active <= 1'b0;
    end else if (i_start) begin
      r_active <= (w_liveTarget != 4'd0);
    end else if (i_step && !w_inRange) begin
      r_active <= 1'b0;
    end
  end
`else
  logic [3:0] r_target;

  assign o_pulse = i_step & r_active;

  // The lane pulses on steps 1..T and drops out after the step that equals T.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_active <= 1'b0;
      r_target <= 4'd0;
    end else if (i_start) begin
      r_active <= (w_liveTarget != 4'd0);
      r_target <= w_liveTarget;
    end else if (i_step && (i_k == r_target)) begin
      r_active <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/tia_hmove_ctrl.sv
// HMOVE sequencer: step timing, five motion lanes and the late-HBLANK extension.
// Optional build macro TIA_HMOVE_LIVE_CMP_EN selects live HMxx comparison in the lanes.
module tia_hmove_ctrl
  import tia_pkg::*;
#(
  parameter int STEP_TICKS     = STEP_TICKS_DEF,
  parameter int NUM_STEPS      = NUM_STEPS_DEF,
  parameter int LATE_BLANK_LEN = LATE_BLANK_LEN_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce,
  input  logic                 hmove,
  input  logic                 hblank,
  input  logic [4*NUM_OBJ-1:0] hm,
  output logic [NUM_OBJ-1:0]   mclk,
  output logic                 busy,
  output logic                 late_blank
);

  localparam int PW = $clog2(STEP_TICKS + 1);
  localparam int LW = $clog2(LATE_BLANK_LEN + 1);

  seq_state_t         r_seqState;
  logic [PW-1:0]      r_phase;
  logic [3:0]         r_k;
  logic               r_busy;
  lb_state_t          r_lbState;
  logic [LW-1:0]      r_lbCount;
  logic               r_lateBlank;
  logic               w_start;
  logic               w_step;
  logic [3:0]         w_kNext;
  logic [NUM_OBJ-1:0] w_pulse;

  // r_phase holds the position of the current ce tick within a step window (1..STEP_TICKS).
  assign w_start = ce & hmove;
  assign w_step  = ce & ~hmove & ~reset & (r_seqState == SEQ_RUN) &
                   (r_phase == PW'(STEP_TICKS));
  assign w_kNext = r_k + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_seqState <= SEQ_IDLE;
      r_phase    <= '0;
      r_k        <= 4'd0;
      r_busy     <= 1'b0;
    end else if (ce) begin
      if (hmove) begin
        r_seqState <= SEQ_RUN;
        r_phase    <= PW'(1);
        r_k        <= 4'd0;
        r_busy     <= 1'b1;
      end else if (r_seqState == SEQ_RUN) begin
        if (r_phase == PW'(STEP_TICKS)) begin
          r_phase <= PW'(1);
          r_k     <= w_kNext;
          if (r_k == 4'(NUM_STEPS - 1)) begin
            r_seqState <= SEQ_IDLE;
            r_busy     <= 1'b0;
          end
        end else begin
          r_phase <= r_phase + PW'(1);
        end
      end
    end
  end

  // A strobe during blank arms the mask; only visible ce ticks count it down.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lbState   <= LB_OFF;
      r_lbCount   <= '0;
      r_lateBlank <= 1'b0;
    end else if (ce) begin
      if (hmove && hblank) begin
        if (r_lbState == LB_OFF) begin
          r_lbState   <= LB_ON;
          r_lbCount   <= '0;
          r_lateBlank <= 1'b1;
        end
      end else if ((r_lbState == LB_ON) && !hblank) begin
        if (r_lbCount == LW'(LATE_BLANK_LEN - 1)) begin
          r_lbState   <= LB_OFF;
          r_lbCount   <= '0;
          r_lateBlank <= 1'b0;
        end else begin
          r_lbCount <= r_lbCount + LW'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_lane
    tia_motion_lane u_lane (
      .clk     (clk),
      .reset   (reset),
      .i_start (w_start),
      .i_step  (w_step),
      .i_k     (w_kNext),
      .i_hm    (hm[4*g +: 4]),
      .o_pulse (w_pulse[g])
    );
  end

  assign mclk       = w_pulse;
  assign busy       = r_busy;
  assign late_blank = r_lateBlank;

endmodule

// File: tb/tb_tia_hmove_ctrl.sv
// Bench for tia_hmove_ctrl: table-driven HMOVE vectors plus hand-written retrigger,
// mid-sequence hm change and reset-abort sequences.
module tb_tia_hmove_ctrl;

  logic        clk;
  logic        reset;
  logic        ce;
  logic        hmove;
  logic        hblank;
  logic [19:0] hm;
  logic [4:0]  mclk;
  logic        busy;
  logic        late_blank;

  int          total;
  int          bad;
  logic [4:0]  sMclk;
  logic        sBusy;
  logic        sLate;
  int          pulseCnt [5];

  typedef struct packed {
    logic [19:0] hm;
    logic [7:0]  fall;
    logic [1:0]  div;
    logic [19:0] expCnt;
  } vec_t;

  vec_t vecs [5];

  tia_hmove_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .ce         (ce),
    .hmove      (hmove),
    .hblank     (hblank),
    .hm         (hm),
    .mclk       (mclk),
    .busy       (busy),
    .late_blank (late_blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one clock cycle of inputs and sample outputs mid-cycle, away from the edge.
  task automatic applyStimulus(input logic iCe, input logic iHmove, input logic iHblank,
                               input logic [19:0] iHm);
    ce     = iCe;
    hmove  = iHmove;
    hblank = iHblank;
    hm     = iHm;
    #3;
    sMclk = mclk;
    sBusy = busy;
    sLate = late_blank;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clearCnt();
    for (int o = 0; o < 5; o++) pulseCnt[o] = 0;
  endtask

  task automatic countPulses();
    for (int o = 0; o < 5; o++) if (sMclk[o] === 1'b1) pulseCnt[o]++;
  endtask

  // Steps fall on ticks 4,8,..,60; lane o pulses on step k while k <= hm[o]^8.
  function automatic logic [4:0] expPulse(input int n, input logic [19:0] hv);
    logic [4:0] r;
    logic [3:0] t;
    r = 5'd0;
    for (int o = 0; o < 5; o++) begin
      t = hv[4*o +: 4] ^ 4'h8;
      r[o] = ((n % 4) == 0) && (n >= 4) && (n <= 60) && ((n / 4) <= int'(t));
    end
    return r;
  endfunction

  function automatic logic expBusy(input int n);
    return (n >= 1) && (n <= 60);
  endfunction

  function automatic logic expLate(input int n, input int fall);
    return (fall > 0) && (n >= 1) && (n <= fall + 7);
  endfunction

  task automatic runVector(input int idx, input vec_t v);
    int   n;
    int   c;
    int   fall;
    int   div;
    logic ceNow;
    logic [4:0] e;
    fall = int'(v.fall);
    div  = int'(v.div);
    clearCnt();
    applyStimulus(1'b1, 1'b1, fall > 0, v.hm);
    checkOutput($sformatf("v%0d_strobeMclk", idx), 32'(sMclk), 32'd0);
    n = 1;
    c = 1;
    while (n <= 66) begin
      ceNow = ((c % div) == 0);
      applyStimulus(ceNow, 1'b0, n < fall, v.hm);
      e = ceNow ? expPulse(n, v.hm) : 5'd0;
      checkOutput($sformatf("v%0d_mclk_n%0d_c%0d", idx, n, c), 32'(sMclk), 32'(e));
      checkOutput($sformatf("v%0d_busy_n%0d_c%0d", idx, n, c), 32'(sBusy), 32'(expBusy(n)));
      checkOutput($sformatf("v%0d_late_n%0d_c%0d", idx, n, c), 32'(sLate),
                  32'(expLate(n, fall)));
      countPulses();
      if (ceNow) n++;
      c++;
    end
    for (int o = 0; o < 5; o++)
      checkOutput($sformatf("v%0d_count_lane%0d", idx, o), pulseCnt[o],
                  32'(v.expCnt[4*o +: 4]));
  endtask

  initial begin
    int fifth;
    int busyOk;
    int sumCnt;
    logic [19:0] hmv;

    total  = 0;
    bad    = 0;
    reset  = 1'b1;
    ce     = 1'b0;
    hmove  = 1'b0;
    hblank = 1'b0;
    hm     = 20'h0;

    vecs[0] = '{hm: 20'h00000, fall: 8'd20, div: 2'd1, expCnt: 20'h88888};
    vecs[1] = '{hm: 20'hF0087, fall: 8'd5,  div: 2'd1, expCnt: 20'h7880F};
    vecs[2] = '{hm: 20'h88888, fall: 8'd0,  div: 2'd2, expCnt: 20'h00000};
    vecs[3] = '{hm: 20'h77777, fall: 8'd0,  div: 2'd1, expCnt: 20'hFFFFF};
    vecs[4] = '{hm: 20'h3C9F1, fall: 8'd10, div: 2'd3, expCnt: 20'hB4179};

    // Reset state
    applyStimulus(1'b1, 1'b0, 1'b1, 20'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 20'h0);
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1, 20'h0);
    checkOutput("reset_mclk", 32'(sMclk), 32'd0);
    checkOutput("reset_busy", 32'(sBusy), 32'd0);
    checkOutput("reset_late", 32'(sLate), 32'd0);

    for (int i = 0; i < 5; i++) runVector(i, vecs[i]);

    // Retrigger at tick 18 with T=8: 4 old pulses, then 8 new ones starting at tick 22
    clearCnt();
    fifth  = -1;
    busyOk = 1;
    applyStimulus(1'b1, 1'b1, 1'b0, 20'h0);
    for (int t = 1; t <= 80; t++) begin
      applyStimulus(1'b1, t == 18, 1'b0, 20'h0);
      if (t <= 78 && sBusy !== 1'b1) busyOk = 0;
      countPulses();
      if (pulseCnt[0] == 5 && fifth < 0) fifth = t;
    end
    checkOutput("retrig_count_p0", pulseCnt[0], 32'd12);
    sumCnt = 0;
    for (int o = 0; o < 5; o++) sumCnt += pulseCnt[o];
    checkOutput("retrig_count_all", sumCnt, 32'd60);
    checkOutput("retrig_fifth_tick", fifth, 32'd22);
    checkOutput("retrig_busy_cont", busyOk, 32'd1);
    checkOutput("retrig_busy_end", 32'(sBusy), 32'd0);

    // P0 hm changes 0 -> 7 at tick 10
    clearCnt();
    applyStimulus(1'b1, 1'b1, 1'b0, 20'h0);
    for (int t = 1; t <= 64; t++) begin
      hmv = (t >= 10) ? 20'h00007 : 20'h00000;
      applyStimulus(1'b1, 1'b0, 1'b0, hmv);
      countPulses();
    end
`ifdef TIA_HMOVE_LIVE_CMP_EN
    checkOutput("hmchg_count_p0", pulseCnt[0], 32'd15);
`else
    checkOutput("hmchg_count_p0", pulseCnt[0], 32'd8);
`endif
    checkOutput("hmchg_count_p1", pulseCnt[1], 32'd8);

    // Reset at tick 30 aborts the sequence and the blank mask
    clearCnt();
    applyStimulus(1'b1, 1'b1, 1'b1, 20'h0);
    for (int t = 1; t <= 29; t++) applyStimulus(1'b1, 1'b0, t < 25, 20'h0);
    checkOutput("rst_pre_busy", 32'(sBusy), 32'd1);
    checkOutput("rst_pre_late", 32'(sLate), 32'd1);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 20'h0);
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 20'h0);
    checkOutput("rst_mclk", 32'(sMclk), 32'd0);
    checkOutput("rst_busy", 32'(sBusy), 32'd0);
    checkOutput("rst_late", 32'(sLate), 32'd0);
    for (int t = 0; t < 40; t++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 20'h0);
      countPulses();
    end
    checkOutput("rst_no_pulses", pulseCnt[0], 32'd0);
    checkOutput("rst_busy_after", 32'(sBusy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
